freq_div_ratio_arb: RTL

FREQ_DIV_RATIO_ARB -- requirements
Module: freq_div_ratio_arb

---
 rtl/freq_div_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/freq_div_ratio_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants and FSM encoding for the divider ratio-update arbiter.
package freq_div_pkg;

  localparam int RATIO_W     = 10;
  localparam int MIN_RATIO   = 2;
  localparam int DEF_TMO_CYC = 255;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DREQ,
    DREL,
    DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after i_last_grant.
module rr_arbiter
  import freq_div_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [NREQ-1:0]  o_gnt
);

  always_comb begin
    int pos;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    o_gnt = '0;
    pos   = 0;
    // Scan from farthest to nearest so the nearest pending requester wins.
    for (int k = NREQ; k >= 1; k--) begin
      pos = (int'(i_last_grant) + k) % NREQ;
      if (i_req[IDX_W'(pos)]) begin
        o_gnt                = '0;
        o_gnt[IDX_W'(pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_div_ratio_arb.sv
// Arbitrates NREQ ratio-update requesters onto a single divider update
// handshake, rejecting ratios below MIN_RATIO and timing out a silent divider.
module freq_div_ratio_arb
  import freq_div_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int RATIO_W = freq_div_pkg::RATIO_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic                      clkin,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*RATIO_W-1:0]   req_ratio,
  output logic [NREQ-1:0]           ack,
  output logic                      err,
  output logic [RATIO_W-1:0]        div_ratio,
  output logic                      div_upd_req,
  input  logic                      div_upd_ack,
  output logic                      busy
);

  localparam int                 IDX_W     = idx_w(NREQ);
  localparam int                 CNT_W     = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [RATIO_W-1:0] RATIO_MIN = RATIO_W'(MIN_RATIO);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, r_last_grant, w_gnt_idx;
  logic [RATIO_W-1:0] r_ratio, r_div_ratio, r_ok_ratio;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [NREQ-1:0]    w_req_pend, w_gnt;
  logic               w_timeout;

  assign w_req_pend = req & ~ack;
  assign w_timeout  = (r_cnt == TMO_LAST);

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req        (w_req_pend),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) w_gnt_idx = IDX_W'(i);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_req_pend) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = (r_ratio < RATIO_MIN) ? DONE : DREQ;
      DREQ:    if (div_upd_ack || w_timeout) w_state_nxt = DREL;
      DREL:    if (!div_upd_ack || w_timeout) w_state_nxt = DONE;
      DONE:    if (!req[r_idx]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_last_grant <= IDX_W'(NREQ - 1);
      r_ratio      <= RATIO_MIN;
      r_div_ratio  <= RATIO_MIN;
      r_ok_ratio   <= RATIO_MIN;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if ((r_state == DREQ || r_state == DREL) && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;

      case (r_state)
        IDLE: if (|w_req_pend) begin
          r_idx   <= w_gnt_idx;
          r_ratio <= req_ratio[w_gnt_idx*RATIO_W +: RATIO_W];
        end
        CHECK: if (r_ratio < RATIO_MIN) r_err <= 1'b1;
               else                     r_div_ratio <= r_ratio;
        // A divider that never acked keeps its old ratio, so restore it.
        DREQ: if (div_upd_ack) r_ok_ratio <= r_div_ratio;
              else if (w_timeout) begin
                r_err       <= 1'b1;
                r_div_ratio <= r_ok_ratio;
              end
        DREL: if (div_upd_ack && w_timeout) r_err <= 1'b1;
        DONE: if (!req[r_idx]) begin
          r_last_grant <= r_idx;
          r_err        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (r_state == DONE) ack[r_idx] = 1'b1;
  end

  assign err         = (r_state == DONE) && r_err;
  assign div_ratio   = r_div_ratio;
  assign div_upd_req = (r_state == DREQ);
  assign busy        = (r_state != IDLE);

endmodule
